// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : game_pkg
// Description : Types and playfield geometry shared by the block spawner and
//               the colour mapper. Holds the spawner FSM encoding, playfield
//               limits, the LFSR seed and the spawn X-offset fold helper.
// Revision    : 1.0 - initial release
//==============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        MOVE       = 2'd2,
        SPAWN      = 2'd3
    } state_t;

    localparam int PLAY_X_MIN = 150;
    localparam int PLAY_X_MAX = 490;
    localparam int Y_BOTTOM   = 479;

    localparam logic [9:0] LFSR_SEED    = 10'h2A5;
    localparam logic [8:0] X_FOLD_LIMIT = 9'd332;

    // Map a 9-bit random value onto 0..332. Values above the limit are folded
    // down by 256 so the result always fits the playfield width.
    function automatic logic [9:0] x_offset(input logic [8:0] rnd);
        logic [8:0] r;
        r = (rnd <= X_FOLD_LIMIT) ? rnd : (rnd - 9'd256);
        return {1'b0, r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr10.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : lfsr10
// Description : 10-bit Fibonacci LFSR (x^10 + x^7 + 1), free running, one step
//               per clock. Maximal length, so the all-zero state never occurs.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset (loads the seed)
//               o_rnd  - low 9 bits of the LFSR state
// Revision    : 1.0 - initial release
//==============================================================================
module lfsr10
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] o_rnd
);

    logic [9:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[8:0], r_q[9] ^ r_q[6]};
        end
    end

    assign o_rnd = r_q[8:0];

endmodule
`default_nettype wire

// File: rtl/block_spawner.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : block_spawner
// Description : Manages NUM_BLOCKS falling blocks. Once per frame (synchronised
//               rising edge of frame_clk) every active slot is moved down one at
//               a time, slots reaching the bottom are retired, and a new block
//               may be spawned at a pseudo-random X in the lowest free slot.
// Ports       : Clk, Reset_n     - clock, asynchronous active-low reset
//               frame_clk        - vsync-rate pulse, asynchronous to Clk
//               level_one/_two   - level select (level two has priority)
//               hit[i]           - clear slot i
//               BlockX/BlockY    - packed 10-bit left/top edge per slot
//               Block_size       - packed 10-bit extent per slot (constant)
//               block_ready[i]   - slot i active
// Revision    : 1.0 - initial release
//==============================================================================
module block_spawner
    import game_pkg::*;
#(
    parameter int NUM_BLOCKS      = 10,
    parameter int BLOCK_SIZE      = 8,
    parameter int SPAWN_PERIOD_L1 = 60,
    parameter int SPAWN_PERIOD_L2 = 30,
    parameter int SPEED_L1        = 1,
    parameter int SPEED_L2        = 2,
    parameter int PLAY_X_MIN      = game_pkg::PLAY_X_MIN,
    parameter int PLAY_X_MAX      = game_pkg::PLAY_X_MAX,
    parameter int Y_BOTTOM        = game_pkg::Y_BOTTOM
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk,
    input  logic                     level_one,
    input  logic                     level_two,
    input  logic [NUM_BLOCKS-1:0]    hit,
    output logic [10*NUM_BLOCKS-1:0] BlockX,
    output logic [10*NUM_BLOCKS-1:0] BlockY,
    output logic [10*NUM_BLOCKS-1:0] Block_size,
    output logic [NUM_BLOCKS-1:0]    block_ready
);

    localparam int c_IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int c_CNT_W = 16;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(NUM_BLOCKS - 1);
    localparam logic [c_CNT_W-1:0] c_PER_L1_M1  = c_CNT_W'(SPAWN_PERIOD_L1 - 1);
    localparam logic [c_CNT_W-1:0] c_PER_L2_M1  = c_CNT_W'(SPAWN_PERIOD_L2 - 1);
    localparam logic [9:0]         c_SPEED_L1   = 10'(SPEED_L1);
    localparam logic [9:0]         c_SPEED_L2   = 10'(SPEED_L2);
    localparam logic [9:0]         c_BLOCK_SZ   = 10'(BLOCK_SIZE);
    localparam logic [9:0]         c_Y_BOTTOM   = 10'(Y_BOTTOM);
    localparam logic [9:0]         c_X_MIN      = 10'(PLAY_X_MIN);
    localparam logic [9:0]         c_X_LIMIT    = 10'(PLAY_X_MAX - BLOCK_SIZE);

    // frame_clk synchroniser (2 flops) plus edge-detect delay flop
    logic r_fc_s1;
    logic r_fc_s2;
    logic r_fc_d;
    logic w_frame_tick;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_IDX_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [NUM_BLOCKS-1:0] r_ready;
    logic [9:0]            r_x [NUM_BLOCKS];
    logic [9:0]            r_y [NUM_BLOCKS];

    logic                  w_level_any;
    logic [9:0]            w_speed;
    logic [c_CNT_W-1:0]    w_period_m1;
    logic [9:0]            w_cur_y;
    logic                  w_retire;
    logic                  w_free_found;
    logic [c_IDX_W-1:0]    w_free_idx;
    logic [8:0]            w_rnd;
    logic [9:0]            w_spawn_x_raw;
    logic [9:0]            w_spawn_x;

    //--------------------------------------------------------------------------
    // Frame tick
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fc_s1 <= 1'b0;
            r_fc_s2 <= 1'b0;
            r_fc_d  <= 1'b0;
        end else begin
            r_fc_s1 <= frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_d  <= r_fc_s2;
        end
    end

    assign w_frame_tick = r_fc_s2 & ~r_fc_d;

    //--------------------------------------------------------------------------
    // Random source
    //--------------------------------------------------------------------------
    lfsr10 u_lfsr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .o_rnd (w_rnd)
    );

    // Clamp only matters if the playfield parameters are narrowed below the
    // fold range; with the default geometry it never engages.
    assign w_spawn_x_raw = c_X_MIN + x_offset(w_rnd);
    assign w_spawn_x     = (w_spawn_x_raw > c_X_LIMIT) ? c_X_LIMIT : w_spawn_x_raw;

    //--------------------------------------------------------------------------
    // Level-dependent parameters
    //--------------------------------------------------------------------------
    assign w_level_any = level_one | level_two;
    assign w_speed     = level_two ? c_SPEED_L2  : c_SPEED_L1;
    assign w_period_m1 = level_two ? c_PER_L2_M1 : c_PER_L1_M1;

    // Retire test on the slot being moved; all terms 10-bit, max sum 480.
    assign w_cur_y  = r_y[r_idx];
    assign w_retire = (w_cur_y + w_speed + c_BLOCK_SZ) > c_Y_BOTTOM;

    // Lowest-index free slot: scan high to low so the lowest match wins.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (!r_ready[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_level_any) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:       w_state_nxt = WAIT_FRAME;
                WAIT_FRAME: if (w_frame_tick) w_state_nxt = MOVE;
                MOVE:       if (r_idx == c_LAST_IDX) w_state_nxt = SPAWN;
                SPAWN:      w_state_nxt = WAIT_FRAME;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Slot datapath. All slot state lives in one process with one async reset,
    // so a reset mid-frame never exposes a half-updated slot.
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ready <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else if (!w_level_any) begin
            r_ready <= '0;
        end else begin
            // Hits clear in every state; the later assignments below only
            // touch the moved slot (skipped when hit) or a slot that was free.
            r_ready <= r_ready & ~hit;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                end
                WAIT_FRAME: begin
                    if (w_frame_tick) begin
                        r_idx <= '0;
                    end
                end
                MOVE: begin
                    if (r_ready[r_idx] && !hit[r_idx]) begin
                        if (w_retire) begin
                            r_ready[r_idx] <= 1'b0;
                        end else begin
                            r_y[r_idx] <= w_cur_y + w_speed;
                        end
                    end
                    r_idx <= r_idx + c_IDX_W'(1);
                end
                SPAWN: begin
                    if (r_cnt == '0) begin
                        if (w_free_found) begin
                            r_ready[w_free_idx] <= 1'b1;
                            r_x[w_free_idx]     <= w_spawn_x;
                            r_y[w_free_idx]     <= '0;
                        end
                        r_cnt <= w_period_m1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign block_ready = r_ready;

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_out
        assign BlockX[g*10 +: 10]     = r_x[g];
        assign BlockY[g*10 +: 10]     = r_y[g];
        assign Block_size[g*10 +: 10] = c_BLOCK_SZ;
    end

endmodule
`default_nettype wire

// File: tb/tb_block_spawner.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_block_spawner
// Description : Directed self-checking bench for block_spawner.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_block_spawner;

    localparam int N = 10;

    logic           Clk       = 1'b0;
    logic           Reset_n   = 1'b0;
    logic           frame_clk = 1'b0;
    logic           level_one = 1'b0;
    logic           level_two = 1'b0;
    logic [N-1:0]   hit       = '0;
    logic [10*N-1:0] BlockX;
    logic [10*N-1:0] BlockY;
    logic [10*N-1:0] Block_size;
    logic [N-1:0]   block_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // reference LFSR and spawn-X bookkeeping
    logic [9:0]   m_lfsr;
    logic [9:0]   m_lfsr_prev;
    logic [9:0]   exp_x [N];
    logic [N-1:0] prev_ready = '0;

    always #5 Clk = ~Clk;

    block_spawner dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .level_one   (level_one),
        .level_two   (level_two),
        .hit         (hit),
        .BlockX      (BlockX),
        .BlockY      (BlockY),
        .Block_size  (Block_size),
        .block_ready (block_ready)
    );

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_lfsr      <= 10'h2A5;
            m_lfsr_prev <= 10'h2A5;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] ref_x(input logic [9:0] q);
        logic [9:0] r;
        r = {1'b0, q[8:0]};
        if (r > 10'd332) r = r - 10'd256;
        return 10'd150 + r;
    endfunction

    function automatic logic [9:0] bx(input int i);
        return BlockX[i*10 +: 10];
    endfunction

    function automatic logic [9:0] by(input int i);
        return BlockY[i*10 +: 10];
    endfunction

    // One clock; sample #1 after the edge and record expected X of new spawns.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (block_ready[i] && !prev_ready[i]) exp_x[i] = ref_x(m_lfsr_prev);
            end
            prev_ready = block_ready;
        end
    endtask

    task automatic apply_reset();
        Reset_n   = 1'b0;
        level_one = 1'b0;
        level_two = 1'b0;
        hit       = '0;
        frame_clk = 1'b0;
        cyc(2);
        Reset_n    = 1'b1;
        prev_ready = '0;
        cyc(2);
    endtask

    // One frame: tick lands after edge 2, slot k is moved on edge 4+k,
    // spawn on edge 4+N. Optionally pulse a hit mask during MOVE of slot pslot.
    task automatic do_frame(input logic [N-1:0] pmask, input int pslot);
        frame_clk = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            if (c == 2) frame_clk = 1'b0;
            if (pslot >= 0 && c == 3 + pslot) hit = hit | pmask;
            if (pslot >= 0 && c == 4 + pslot) begin
                hit = hit & ~pmask;
                n_checks++;
                if ((block_ready & pmask) !== '0) begin
                    n_fail++;
                    $display("FAIL hit_next_clk: ready=%b mask=%b want cleared", block_ready, pmask);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #2;
        n_checks++;
        if (block_ready !== '0) begin
            n_fail++; $display("FAIL rst_ready: got %b want 0", block_ready);
        end
        n_checks++;
        if (BlockX !== '0 || BlockY !== '0) begin
            n_fail++; $display("FAIL rst_xy: X=%h Y=%h want 0", BlockX, BlockY);
        end
        n_checks++;
        if (Block_size !== {N{10'd8}}) begin
            n_fail++; $display("FAIL rst_size: got %h want all 8", Block_size);
        end
        apply_reset();
        do_frame('0, -1);
        n_checks++;
        if (block_ready !== '0 || BlockY !== '0) begin
            n_fail++; $display("FAIL idle_no_level: ready=%b Y=%h want 0", block_ready, BlockY);
        end
    endtask

    task automatic test_level_one();
        apply_reset();
        level_one = 1'b1;
        cyc(3);
        do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b1 || by(0) !== 10'd0) begin
            n_fail++; $display("FAIL l1_first: ready=%b Y0=%0d want 0000000001/0", block_ready, by(0));
        end
        n_checks++;
        if (bx(0) !== exp_x[0] || bx(0) < 10'd150 || bx(0) > 10'd482) begin
            n_fail++; $display("FAIL l1_x0: got %0d want %0d (150..482)", bx(0), exp_x[0]);
        end
        for (int f = 0; f < 59; f++) do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b1 || by(0) !== 10'd59) begin
            n_fail++; $display("FAIL l1_f60: ready=%b Y0=%0d want 1/59", block_ready, by(0));
        end
        do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b11 || by(0) !== 10'd60 || by(1) !== 10'd0 || bx(1) !== exp_x[1]) begin
            n_fail++;
            $display("FAIL l1_f61: ready=%b Y0=%0d Y1=%0d X1=%0d want 11/60/0/%0d",
                     block_ready, by(0), by(1), bx(1), exp_x[1]);
        end
    endtask

    task automatic test_level_two_retire();
        apply_reset();
        level_two = 1'b1;
        hit       = 10'b1111111110;   // keep every other slot empty
        cyc(3);
        do_frame('0, -1);
        do_frame('0, -1);
        n_checks++;
        if (block_ready[0] !== 1'b1 || by(0) !== 10'd2) begin
            n_fail++; $display("FAIL l2_speed: ready0=%b Y0=%0d want 1/2", block_ready[0], by(0));
        end
        for (int f = 0; f < 234; f++) do_frame('0, -1);
        n_checks++;
        if (block_ready[0] !== 1'b1 || by(0) !== 10'd470) begin
            n_fail++; $display("FAIL l2_y470: ready0=%b Y0=%0d want 1/470", block_ready[0], by(0));
        end
        do_frame('0, -1);
        n_checks++;
        if (block_ready[0] !== 1'b0 || by(0) !== 10'd470) begin
            n_fail++; $display("FAIL l2_retire: ready0=%b Y0=%0d want 0/470", block_ready[0], by(0));
        end
        hit = '0;
    endtask

    task automatic test_hit();
        apply_reset();
        level_one = 1'b1;
        cyc(3);
        do_frame('0, -1);
        do_frame(10'b1, 0);
        n_checks++;
        if (block_ready !== '0 || by(0) !== 10'd0) begin
            n_fail++; $display("FAIL hit_noinc: ready=%b Y0=%0d want 0/0", block_ready, by(0));
        end
        for (int f = 0; f < 58; f++) do_frame('0, -1);
        n_checks++;
        if (block_ready !== '0) begin
            n_fail++; $display("FAIL hit_early: ready=%b want 0", block_ready);
        end
        do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b1 || by(0) !== 10'd0 || bx(0) !== exp_x[0]) begin
            n_fail++; $display("FAIL hit_reuse: ready=%b Y0=%0d X0=%0d want 1/0/%0d",
                               block_ready, by(0), bx(0), exp_x[0]);
        end
    endtask

    task automatic test_full();
        apply_reset();
        level_one = 1'b1;
        cyc(3);
        // level two on spawn frames only: period 30 reloads, speed 2 that frame
        for (int f = 1; f <= 301; f++) begin
            level_two = ((f - 1) % 30 == 0);
            do_frame('0, -1);
            level_two = 1'b0;
        end
        n_checks++;
        if (block_ready !== {N{1'b1}}) begin
            n_fail++; $display("FAIL full_ready: got %b want all 1", block_ready);
        end
        for (int s = 0; s < N; s++) begin
            n_checks++;
            if (by(s) !== 10'(310 - 31*s) || bx(s) !== exp_x[s]) begin
                n_fail++; $display("FAIL full_slot%0d: Y=%0d X=%0d want %0d/%0d",
                                   s, by(s), bx(s), 310 - 31*s, exp_x[s]);
            end
        end
        hit[3] = 1'b1;
        cyc(1);
        hit[3] = 1'b0;
        for (int f = 302; f <= 330; f++) do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b1111110111) begin
            n_fail++; $display("FAIL full_before: ready=%b want 1111110111", block_ready);
        end
        level_two = 1'b1;
        do_frame('0, -1);
        level_two = 1'b0;
        n_checks++;
        if (block_ready !== {N{1'b1}} || by(3) !== 10'd0 || bx(3) !== exp_x[3]) begin
            n_fail++; $display("FAIL full_respawn: ready=%b Y3=%0d X3=%0d want all1/0/%0d",
                               block_ready, by(3), bx(3), exp_x[3]);
        end
    endtask

    task automatic test_drop_and_reset();
        logic [9:0] x0;
        apply_reset();
        level_one = 1'b1;
        cyc(3);
        do_frame('0, -1);
        x0 = exp_x[0];
        frame_clk = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc(1);
            if (c == 2) frame_clk = 1'b0;
        end
        level_one = 1'b0;           // slot 2 is being moved now
        cyc(1);
        n_checks++;
        if (block_ready !== '0 || bx(0) !== x0 || by(0) !== 10'd1) begin
            n_fail++; $display("FAIL drop_mid_move: ready=%b X0=%0d Y0=%0d want 0/%0d/1",
                               block_ready, bx(0), by(0), x0);
        end
        cyc(5);
        level_one = 1'b1;
        cyc(3);
        frame_clk = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc(1);
            if (c == 2) frame_clk = 1'b0;
        end
        Reset_n = 1'b0;             // FSM is in SPAWN for this cycle
        #1;
        n_checks++;
        if (block_ready !== '0 || BlockX !== '0 || BlockY !== '0) begin
            n_fail++; $display("FAIL rst_mid_spawn: ready=%b X=%h Y=%h want 0", block_ready, BlockX, BlockY);
        end
        cyc(2);
        Reset_n    = 1'b1;
        prev_ready = '0;
        cyc(3);
        do_frame('0, -1);
        n_checks++;
        if (block_ready !== 10'b1 || bx(0) !== exp_x[0]) begin
            n_fail++; $display("FAIL post_rst_spawn: ready=%b X0=%0d want 1/%0d",
                               block_ready, bx(0), exp_x[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_x[i] = '0;
        test_reset();
        test_level_one();
        test_level_two_retire();
        test_hit();
        test_full();
        test_drop_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
